// File: rtl/m8c_issp_vecseq_pkg.sv
// Shared definitions for the M8C ISSP vector sequencer: command codes, sizes and FSM states.
package m8c_issp_vecseq_pkg;

  localparam logic [7:0] ISSPCMD_NONE    = 8'd0;
  localparam logic [7:0] ISSPCMD_POR     = 8'd1;
  localparam logic [7:0] ISSPCMD_PWROFF  = 8'd2;
  localparam logic [7:0] ISSPCMD_SENDVEC = 8'd3;
  localparam logic [7:0] ISSPCMD_EXEC    = 8'd4;

  localparam int ISSP_VEC_SIZE = 22;
  localparam int VEC_SIZE      = ISSP_VEC_SIZE;
  localparam int DEPTH         = 8;
  localparam int AW            = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE_VEC  = 3'd1,
    ST_WAIT_VEC   = 3'd2,
    ST_STORE      = 3'd3,
    ST_ISSUE_EXEC = 3'd4,
    ST_WAIT_EXEC  = 3'd5
  } state_t;

endpackage

// File: rtl/m8c_issp_vecseq_if.sv
// Host queue and bit-engine command signals of the vector sequencer; slave = sequencer view.
interface m8c_issp_vecseq_if;
  import m8c_issp_vecseq_pkg::*;

  logic                flush;
  logic                vec_wr;
  logic [VEC_SIZE-1:0] vec_data;
  logic [VEC_SIZE-1:0] vec_mask;
  logic                vec_exec;
  logic                cmd_full;
  logic [AW:0]         cmd_level;
  logic                res_rd;
  logic [VEC_SIZE-1:0] res_data;
  logic                res_empty;
  logic                overflow;
  logic                seq_busy;
  logic                eng_start;
  logic [7:0]          eng_cmd;
  logic [VEC_SIZE-1:0] eng_vector;
  logic [VEC_SIZE-1:0] eng_mask;
  logic                eng_busy;
  logic                eng_done;
  logic [VEC_SIZE-1:0] eng_result;

  modport slave (
    input  flush, vec_wr, vec_data, vec_mask, vec_exec, res_rd,
    input  eng_busy, eng_done, eng_result,
    output cmd_full, cmd_level, res_data, res_empty, overflow, seq_busy,
    output eng_start, eng_cmd, eng_vector, eng_mask
  );

  modport master (
    output flush, vec_wr, vec_data, vec_mask, vec_exec, res_rd,
    output eng_busy, eng_done, eng_result,
    input  cmd_full, cmd_level, res_data, res_empty, overflow, seq_busy,
    input  eng_start, eng_cmd, eng_vector, eng_mask
  );

endinterface

// File: rtl/m8c_issp_fifo.sv
// Synchronous FIFO with registered head, sticky overflow and a clear that beats push/pop.
// Head (o_dout) follows a push into empty or a pop one cycle later; push-when-full is dropped.
module m8c_issp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level,
  output logic          o_overflow
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [W-1:0]  r_dout;
  logic          r_ovf;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_rd_nxt;

  assign o_full     = (r_level == LVL_FULL);
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_dout     = r_dout;
  assign o_overflow = r_ovf;
  assign w_push     = i_push & ~i_clr & ~o_full;
  assign w_pop      = i_pop & ~i_clr & ~o_empty;
  assign w_rd_nxt   = r_rd_ptr + 1'b1;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dout   <= '0;
      r_ovf    <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dout   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if ((i_push && o_full) || (i_pop && o_empty)) r_ovf <= 1'b1;
      // Head register tracks whatever will sit at the read pointer next cycle.
      if (w_pop) begin
        if (r_level > (AW+1)'(1)) r_dout <= r_mem[w_rd_nxt];
        else if (w_push)          r_dout <= i_din;
      end else if (w_push && o_empty) begin
        r_dout <= i_din;
      end
    end
  end

endmodule

// File: rtl/m8c_issp_vecseq.sv
// Queues host ISSP vectors and issues SENDVEC/EXEC to the bit engine back-to-back; masked results go to a result FIFO.
// vec_wr into an idle sequencer gives eng_start two cycles later; a full result FIFO stalls the FSM in STORE.
module m8c_issp_vecseq
  import m8c_issp_vecseq_pkg::*;
(
  input  logic              osc,
  input  logic              rst,
  m8c_issp_vecseq_if.slave  bus
);

  localparam int          CW       = 2*VEC_SIZE + 1;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [CW-1:0]       w_cmd_head;
  logic                w_cmd_empty;
  logic                w_cmd_ovf;
  logic                w_cmd_pop;
  logic                w_res_full;
  logic                w_res_empty;
  logic                w_res_ovf;
  logic                w_res_push;
  logic [AW:0]         w_res_level;

  state_t              r_state;
  logic [VEC_SIZE-1:0] r_vec;
  logic [VEC_SIZE-1:0] r_mask;
  logic [VEC_SIZE-1:0] r_result;
  logic                r_exec;
  logic                r_abort;
  logic                r_eng_start;
  logic [7:0]          r_eng_cmd;

  assign w_cmd_pop  = (r_state == ST_IDLE) & ~bus.flush & ~w_cmd_empty & ~bus.eng_busy;
  assign w_res_push = (r_state == ST_STORE) & ~bus.flush & ~w_res_full;

  m8c_issp_fifo #(.W(CW), .DEPTH(DEPTH), .AW(AW)) u_cmd_fifo (
    .i_clk      (osc),
    .i_rst      (rst),
    .i_clr      (bus.flush),
    .i_push     (bus.vec_wr),
    .i_pop      (w_cmd_pop),
    .i_din      ({bus.vec_exec, bus.vec_mask, bus.vec_data}),
    .o_dout     (w_cmd_head),
    .o_full     (bus.cmd_full),
    .o_empty    (w_cmd_empty),
    .o_level    (bus.cmd_level),
    .o_overflow (w_cmd_ovf)
  );

  m8c_issp_fifo #(.W(VEC_SIZE), .DEPTH(DEPTH), .AW(AW)) u_res_fifo (
    .i_clk      (osc),
    .i_rst      (rst),
    .i_clr      (bus.flush),
    .i_push     (w_res_push),
    .i_pop      (bus.res_rd),
    .i_din      (r_result),
    .o_dout     (bus.res_data),
    .o_full     (w_res_full),
    .o_empty    (w_res_empty),
    .o_level    (w_res_level),
    .o_overflow (w_res_ovf)
  );

  assert property (@(posedge osc) disable iff (rst) w_res_full == (w_res_level == LVL_FULL));

  assign bus.res_empty  = w_res_empty;
  assign bus.overflow   = w_cmd_ovf | w_res_ovf;
  assign bus.seq_busy   = (r_state != ST_IDLE) | ~w_cmd_empty;
  assign bus.eng_start  = r_eng_start;
  assign bus.eng_cmd    = r_eng_cmd;
  assign bus.eng_vector = r_vec;
  assign bus.eng_mask   = r_mask;

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vec       <= '0;
      r_mask      <= '0;
      r_result    <= '0;
      r_exec      <= 1'b0;
      r_abort     <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_cmd   <= ISSPCMD_NONE;
    end else begin
      r_eng_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_pop) begin
            r_vec       <= w_cmd_head[VEC_SIZE-1:0];
            r_mask      <= w_cmd_head[2*VEC_SIZE-1:VEC_SIZE];
            r_exec      <= w_cmd_head[2*VEC_SIZE];
            r_eng_start <= 1'b1;
            r_eng_cmd   <= ISSPCMD_SENDVEC;
            r_state     <= ST_ISSUE_VEC;
          end
        end
        ST_ISSUE_VEC: r_state <= bus.flush ? ST_IDLE : ST_WAIT_VEC;
        ST_WAIT_VEC: begin
          // A flush here only marks the in-flight command; the engine is always allowed to finish.
          if (bus.flush) r_abort <= 1'b1;
          if (bus.eng_done) begin
            r_result <= bus.eng_result;
            r_abort  <= 1'b0;
            if (r_abort || bus.flush) r_state <= ST_IDLE;
            else if (r_mask != '0)    r_state <= ST_STORE;
            else if (r_exec)          r_state <= ST_ISSUE_EXEC;
            else                      r_state <= ST_IDLE;
          end
        end
        ST_STORE: begin
          if (bus.flush) begin
            r_state <= ST_IDLE;
          end else if (!w_res_full) begin
            if (r_exec) begin
              r_eng_start <= 1'b1;
              r_eng_cmd   <= ISSPCMD_EXEC;
              r_state     <= ST_ISSUE_EXEC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_ISSUE_EXEC: begin
          // Entered straight from WAIT_VEC without a strobe: spend one cycle so done->start stays 2 cycles.
          if (bus.flush)        r_state <= ST_IDLE;
          else if (r_eng_start) r_state <= ST_WAIT_EXEC;
          else begin
            r_eng_start <= 1'b1;
            r_eng_cmd   <= ISSPCMD_EXEC;
          end
        end
        ST_WAIT_EXEC: begin
          if (bus.flush) r_abort <= 1'b1;
          if (bus.eng_done) begin
            r_abort <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m8c_issp_vecseq.sv
// Directed bench for m8c_issp_vecseq with a small bit-engine model that returns vector ^ 0xA4.
module tb_m8c_issp_vecseq;
  import m8c_issp_vecseq_pkg::*;

  logic osc = 1'b0;
  logic rst;
  logic eng_hold;
  logic eng_busy_int;
  int   eng_lat;
  int   e_cnt;
  logic [21:0] e_vec;
  int   n_checks = 0;
  int   n_errs   = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [21:0] vec;
    logic [21:0] mask;
  } start_t;
  start_t slog[$];

  typedef struct {
    logic [21:0] data;
    logic [21:0] mask;
    logic        exec;
    logic        exp_store;
    logic [21:0] exp_res;
    int          exp_starts;
  } vrec_t;
  vrec_t tbl[5];

  m8c_issp_vecseq_if bus();

  m8c_issp_vecseq dut (
    .osc (osc),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 osc = ~osc;

  assign bus.eng_busy = eng_hold | eng_busy_int;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge osc);
    #1;
  endtask

  task automatic push(input logic [21:0] d, input logic [21:0] m, input logic e);
    bus.vec_data = d;
    bus.vec_mask = m;
    bus.vec_exec = e;
    bus.vec_wr   = 1'b1;
    tick();
    bus.vec_wr   = 1'b0;
  endtask

  task automatic pop_res();
    bus.res_rd = 1'b1;
    tick();
    bus.res_rd = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (bus.seq_busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle"}, 32'(bus.seq_busy), 32'd0);
  endtask

  // Bit-engine model: takes a strobe when idle, answers eng_lat cycles later.
  initial begin
    eng_busy_int   = 1'b0;
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    e_cnt          = 0;
    e_vec          = '0;
    forever begin
      tick();
      bus.eng_done = 1'b0;
      if (rst) begin
        e_cnt        = 0;
        eng_busy_int = 1'b0;
      end else begin
        if (bus.eng_start) begin
          start_t s;
          s.cmd  = bus.eng_cmd;
          s.vec  = bus.eng_vector;
          s.mask = bus.eng_mask;
          slog.push_back(s);
        end
        if (e_cnt > 0) begin
          e_cnt--;
          if (e_cnt == 0) begin
            check("eng_vector_held", 32'(bus.eng_vector), 32'(e_vec));
            bus.eng_done   = 1'b1;
            bus.eng_result = e_vec ^ 22'h0000A4;
            eng_busy_int   = 1'b0;
          end
        end else if (bus.eng_start) begin
          e_cnt        = eng_lat;
          e_vec        = bus.eng_vector;
          eng_busy_int = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic found;
    tbl[0] = '{22'h2AAAAA, 22'h000000, 1'b0, 1'b0, 22'h000000, 1};
    tbl[1] = '{22'h000001, 22'h0000FF, 1'b1, 1'b1, 22'h0000A5, 2};
    tbl[2] = '{22'h155555, 22'h000000, 1'b1, 1'b0, 22'h000000, 2};
    tbl[3] = '{22'h3FFFFF, 22'h200000, 1'b0, 1'b1, 22'h3FFF5B, 1};
    tbl[4] = '{22'h0000A4, 22'h000001, 1'b1, 1'b1, 22'h000000, 2};

    rst = 1'b1;
    eng_hold = 1'b0;
    eng_lat  = 3;
    bus.flush = 1'b0; bus.vec_wr = 1'b0; bus.res_rd = 1'b0;
    bus.vec_data = '0; bus.vec_mask = '0; bus.vec_exec = 1'b0;
    repeat (3) tick();
    check("rst_cmd_full",   32'(bus.cmd_full),   32'd0);
    check("rst_cmd_level",  32'(bus.cmd_level),  32'd0);
    check("rst_res_empty",  32'(bus.res_empty),  32'd1);
    check("rst_res_data",   32'(bus.res_data),   32'd0);
    check("rst_overflow",   32'(bus.overflow),   32'd0);
    check("rst_seq_busy",   32'(bus.seq_busy),   32'd0);
    check("rst_eng_start",  32'(bus.eng_start),  32'd0);
    check("rst_eng_cmd",    32'(bus.eng_cmd),    32'd0);
    check("rst_eng_vector", 32'(bus.eng_vector), 32'd0);
    check("rst_eng_mask",   32'(bus.eng_mask),   32'd0);
    rst = 1'b0;
    tick();

    // Single vectors through every FSM path.
    for (int i = 0; i < 5; i++) begin
      slog.delete();
      push(tbl[i].data, tbl[i].mask, tbl[i].exec);
      check($sformatf("v%0d_no_start_c1", i), 32'(bus.eng_start), 32'd0);
      tick();
      check($sformatf("v%0d_start_c2", i), 32'(bus.eng_start), 32'd1);
      check($sformatf("v%0d_cmd", i), 32'(bus.eng_cmd), 32'(ISSPCMD_SENDVEC));
      check($sformatf("v%0d_vector", i), 32'(bus.eng_vector), 32'(tbl[i].data));
      check($sformatf("v%0d_mask", i), 32'(bus.eng_mask), 32'(tbl[i].mask));
      wait_idle(60, $sformatf("v%0d", i));
      check($sformatf("v%0d_starts", i), 32'(slog.size()), 32'(tbl[i].exp_starts));
      if (tbl[i].exec && slog.size() > 1)
        check($sformatf("v%0d_exec_cmd", i), 32'(slog[1].cmd), 32'(ISSPCMD_EXEC));
      check($sformatf("v%0d_res_empty", i), 32'(bus.res_empty), 32'(!tbl[i].exp_store));
      if (tbl[i].exp_store) begin
        check($sformatf("v%0d_res_data", i), 32'(bus.res_data), 32'(tbl[i].exp_res));
        pop_res();
        check($sformatf("v%0d_res_drained", i), 32'(bus.res_empty), 32'd1);
      end
    end

    // Command FIFO fill while engine reports busy; ninth push overflows.
    slog.delete();
    eng_hold = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      bus.vec_data = 22'h100 + 22'(i);
      bus.vec_mask = '0;
      bus.vec_exec = 1'b0;
      bus.vec_wr   = 1'b1;
      tick();
      if (i == 7) begin
        check("fill8_cmd_full",  32'(bus.cmd_full),  32'd1);
        check("fill8_cmd_level", 32'(bus.cmd_level), 32'd8);
        check("fill8_overflow",  32'(bus.overflow),  32'd0);
      end
      if (i == 8) begin
        check("fill9_overflow",  32'(bus.overflow),  32'd1);
        check("fill9_cmd_level", 32'(bus.cmd_level), 32'd8);
      end
    end
    bus.vec_wr = 1'b0;
    check("held_no_start", 32'(slog.size()), 32'd0);
    eng_hold = 1'b0;
    wait_idle(200, "fill");
    check("fill_issued", 32'(slog.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < slog.size()) check($sformatf("fill_order%0d", k), 32'(slog[k].vec), 32'h100 + 32'(k));
    do_flush();
    check("flush_clears_ovf", 32'(bus.overflow), 32'd0);

    // Result FIFO full: ninth masked vector stalls in STORE.
    slog.delete();
    for (int i = 0; i < 8; i++) push(22'(i + 1), 22'h000001, 1'b0);
    wait_idle(300, "res8");
    check("res8_not_empty", 32'(bus.res_empty), 32'd0);
    check("res8_issued", 32'(slog.size()), 32'd8);
    slog.delete();
    push(22'h3C0000, 22'h000001, 1'b0);
    push(22'h123456, 22'h000000, 1'b0);
    repeat (20) tick();
    check("stall_one_start", 32'(slog.size()), 32'd1);
    check("stall_busy", 32'(bus.seq_busy), 32'd1);
    check("stall_cmd_level", 32'(bus.cmd_level), 32'd1);
    pop_res();
    check("stall_head_after_pop", 32'(bus.res_data), 32'h0000A6);
    wait_idle(100, "stall_release");
    check("release_starts", 32'(slog.size()), 32'd2);
    if (slog.size() > 1) check("release_next_vec", 32'(slog[1].vec), 32'h123456);
    for (int k = 2; k <= 8; k++) begin
      check($sformatf("drain%0d", k), 32'(bus.res_data), 32'(22'(k) ^ 22'h0000A4));
      pop_res();
    end
    check("drain_last", 32'(bus.res_data), 32'h3C00A4);
    pop_res();
    check("drain_empty", 32'(bus.res_empty), 32'd1);

    // flush while waiting on SENDVEC with three vectors queued.
    slog.delete();
    eng_lat = 10;
    push(22'h0ABCDE, 22'h0000FF, 1'b1);
    n = 0;
    while (!bus.eng_start && n < 20) begin tick(); n++; end
    check("fl_start_seen", 32'(bus.eng_start), 32'd1);
    push(22'h000011, 22'h0000FF, 1'b1);
    push(22'h000022, 22'h0000FF, 1'b1);
    push(22'h000033, 22'h0000FF, 1'b1);
    check("fl_cmd_level_pre", 32'(bus.cmd_level), 32'd3);
    do_flush();
    check("fl_cmd_level", 32'(bus.cmd_level), 32'd0);
    check("fl_busy_waiting", 32'(bus.seq_busy), 32'd1);
    repeat (20) tick();
    check("fl_no_more_start", 32'(slog.size()), 32'd1);
    check("fl_no_result", 32'(bus.res_empty), 32'd1);
    check("fl_idle", 32'(bus.seq_busy), 32'd0);
    eng_lat = 3;

    // Asynchronous reset while the EXEC strobe is out.
    pop_res();
    check("rd_empty_ovf", 32'(bus.overflow), 32'd1);
    push(22'h000005, 22'h000001, 1'b0);
    wait_idle(60, "pre_rst");
    check("pre_rst_res", 32'(bus.res_empty), 32'd0);
    push(22'h2F0F0F, 22'h000000, 1'b1);
    push(22'h000011, 22'h000000, 1'b0);
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      if (bus.eng_start && bus.eng_cmd == ISSPCMD_EXEC) found = 1'b1;
      else begin tick(); n++; end
    end
    check("exec_start_seen", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_eng_start", 32'(bus.eng_start), 32'd0);
    check("arst_eng_cmd",   32'(bus.eng_cmd),   32'd0);
    check("arst_cmd_level", 32'(bus.cmd_level), 32'd0);
    check("arst_res_empty", 32'(bus.res_empty), 32'd1);
    check("arst_overflow",  32'(bus.overflow),  32'd0);
    check("arst_seq_busy",  32'(bus.seq_busy),  32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    push(22'h00BEEF, 22'h000000, 1'b0);
    tick();
    check("post_rst_start", 32'(bus.eng_start), 32'd1);
    wait_idle(60, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
